// File: rtl/puff_timer.sv
// puff_timer: fuel-injector puff controller.
// A rising edge on the asynchronous ign_coil input opens the injector for
// puff_len_us microseconds. A jiffy-based watchdog aborts the puff and stalls
// the controller if ignition edges stop arriving. The next edge after a stall
// only clears the stall.
//
// Ports
//   sysclk              system clock, rising edge
//   sysreset            asynchronous reset, active low
//   pulse1m             one-cycle tick every 1 us (PUFF timebase)
//   pulse50k            one-cycle tick every 20 us (WDOG timebase, one jiffy)
//   ign_coil            asynchronous ignition-coil level
//   ign_timeout_len_jf  watchdog length in jiffies, 0 disables it
//   puff_len_us         injector open time in us, sampled when a puff starts
//   puff_enable         1 allows puffs, 0 closes the injector at once
//   injector_open       registered injector drive
//   puff_event          registered one-cycle pulse on normal puff completion

// Loadable 16-bit down-counter. Load has priority over counting, and the count
// stops at zero.
module cdtimer16 (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        counter_event,
  output logic [15:0] data_out,
  output logic        expired
);
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = data_in;
    else if (counter_event && (count_q != 16'd0))
      count_d = count_q - 16'd1;
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) count_q <= '0;
    else           count_q <= count_d;
  end

  assign data_out = count_q;
  assign expired  = (count_q == 16'd0);
endmodule

// state | meaning
// IDLE  | injector closed, waiting for an ignition edge
// PUFF  | injector open, PUFF timer counting down
// STALL | watchdog expired; next ignition edge only clears the stall
module puff_timer (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        pulse1m,
  input  logic        pulse50k,
  input  logic        ign_coil,
  input  logic [15:0] ign_timeout_len_jf,
  input  logic [15:0] puff_len_us,
  input  logic        puff_enable,
  output logic        injector_open,
  output logic        puff_event
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUFF  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic   valid1_q, valid1_d, valid2_q, valid2_d, seen_low_q, seen_low_d;
  logic   armed_q, armed_d, event_q, event_d;
  logic   ign_rise, wdog_fire;
  logic   start, abort, done;
  logic   puff_load, puff_expired, wdog_expired;
  logic [15:0] puff_data;
  logic [15:0] puff_count_unused, wdog_count_unused;

  // The synchronizer flops come out of reset at 0, so a coil already held high
  // would look like an edge. seen_low only arms edge detection once the
  // synchronized level has been observed low after the chain has filled.
  always_comb begin
    sync1_d    = ign_coil;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    valid1_d   = 1'b1;
    valid2_d   = valid1_q;
    seen_low_d = seen_low_q | (valid2_q & ~sync2_q);
  end

  assign ign_rise = sync2_q & ~prev_q & seen_low_q;

  // armed marks a watchdog run started from a nonzero load; it fires once when
  // that run reaches zero. A simultaneous ignition edge reloads and wins.
  assign wdog_fire = armed_q & wdog_expired & ~ign_rise;

  always_comb begin
    armed_d = armed_q;
    if (ign_rise)       armed_d = (ign_timeout_len_jf != 16'd0);
    else if (wdog_fire) armed_d = 1'b0;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ign_rise && puff_enable && (puff_len_us != 16'd0)) begin
          state_d = ST_PUFF;
          start   = 1'b1;
        end else if (wdog_fire) begin
          state_d = ST_STALL;
        end
      end
      ST_PUFF: begin
        if (wdog_fire) begin
          state_d = ST_STALL;
          abort   = 1'b1;
        end else if (!puff_enable) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (puff_expired) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      ST_STALL: begin
        if (ign_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; an abort loads zero so the PUFF count is cleared
  always_comb begin
    puff_load     = start | abort;
    puff_data     = start ? puff_len_us : 16'd0;
    event_d       = done;
    injector_open = (state_q == ST_PUFF);
    puff_event    = event_q;
  end

  // State register
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      seen_low_q <= 1'b0;
      armed_q    <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      valid1_q   <= valid1_d;
      valid2_q   <= valid2_d;
      seen_low_q <= seen_low_d;
      armed_q    <= armed_d;
      event_q    <= event_d;
    end
  end

  cdtimer16 u_puff (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .data_in       (puff_data),
    .load          (puff_load),
    .counter_event (pulse1m),
    .data_out      (puff_count_unused),
    .expired       (puff_expired)
  );

  cdtimer16 u_wdog (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .data_in       (ign_timeout_len_jf),
    .load          (ign_rise),
    .counter_event (pulse50k),
    .data_out      (wdog_count_unused),
    .expired       (wdog_expired)
  );
endmodule

// File: tb/tb_puff_timer.sv
module tb_puff_timer;
  // Scaled timebase: one "us" tick every P1 clocks, one jiffy every PJ clocks.
  localparam int P1 = 2;
  localparam int PJ = 40;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b0;
  logic        pulse1m = 1'b0;
  logic        pulse50k = 1'b0;
  logic        ign_coil = 1'b0;
  logic [15:0] ign_timeout_len_jf = 16'd0;
  logic [15:0] puff_len_us = 16'd0;
  logic        puff_enable = 1'b0;
  logic        injector_open;
  logic        puff_event;

  puff_timer dut (
    .sysclk             (sysclk),
    .sysreset           (sysreset),
    .pulse1m            (pulse1m),
    .pulse50k           (pulse50k),
    .ign_coil           (ign_coil),
    .ign_timeout_len_jf (ign_timeout_len_jf),
    .puff_len_us        (puff_len_us),
    .puff_enable        (puff_enable),
    .injector_open      (injector_open),
    .puff_event         (puff_event)
  );

  always #10 sysclk = ~sysclk;

  // One expected puff: allowed open duration in clocks and whether it ends with puff_event.
  typedef struct {
    int lo;
    int hi;
    bit ev;
  } exp_t;

  // Table record: settings for one ignition edge and the expected outcome
  // (0 = no puff, 1 = normal puff of len, 2 = watchdog abort after tmo jiffies).
  typedef struct {
    bit en;
    int len;
    int tmo;
    int kind;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_events = 0;
  int   seen_events = 0;
  int   stray_events = 0;
  bit   gen50 = 1'b1;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_norm(input int n);
    exp_t e;
    e.lo = n * P1;
    e.hi = n * P1 + 1;
    e.ev = 1'b1;
    exp_q.push_back(e);
    exp_events++;
  endtask

  task automatic push_wdog(input int t);
    exp_t e;
    e.lo = (t - 1) * PJ;
    e.hi = t * PJ + 2;
    e.ev = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_abort(input int n);
    exp_t e;
    e.lo = 1;
    e.hi = n * P1 - 1;
    e.ev = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Tick generators; pulse50k can be handed over to a sequence via gen50.
  initial forever begin
    @(negedge sysclk);
    cyc++;
    pulse1m = (cyc % P1 == 0);
    if (gen50) pulse50k = (cyc % PJ == 0);
  end

  // Output monitor: measures each injector opening and pops its expectation.
  int  mcyc = 0;
  int  t_rise = 0;
  logic open_prev = 1'b0;
  always @(negedge sysclk) begin
    exp_t e;
    mcyc++;
    if (puff_event) seen_events++;
    if (injector_open && !open_prev) t_rise = mcyc;
    if (!injector_open && open_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_puff_len", mcyc - t_rise, -1, -1);
      end else begin
        e = exp_q.pop_front();
        chk("puff_duration", mcyc - t_rise, e.lo, e.hi);
        chk("puff_event_at_close", int'(puff_event), int'(e.ev), int'(e.ev));
      end
    end else if (puff_event) begin
      stray_events++;
    end
    open_prev = injector_open;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 10,  0,      1};
    vecs[1] = '{1'b1, 0,   0,      0};
    vecs[2] = '{1'b0, 10,  0,      0};
    vecs[3] = '{1'b1, 1,   0,      1};
    vecs[4] = '{1'b1, 25,  16'hFFFC, 1};
    vecs[5] = '{1'b1, 100, 2,      2};
    vecs[6] = '{1'b1, 10,  0,      0};
    vecs[7] = '{1'b1, 10,  0,      1};

    // Reset state
    wait_cyc(3);
    chk("reset_injector_open", int'(injector_open), 0, 0);
    chk("reset_puff_event", int'(puff_event), 0, 0);
    @(negedge sysclk) sysreset = 1'b1;
    puff_enable = 1'b1;
    wait_cyc(5);

    // Table-driven single-edge vectors (sequential: vector 6 relies on the stall from 5)
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      puff_enable = vecs[i].en;
      puff_len_us = 16'(vecs[i].len);
      ign_timeout_len_jf = 16'(vecs[i].tmo);
      if (vecs[i].kind == 1) push_norm(vecs[i].len);
      else if (vecs[i].kind == 2) push_wdog(vecs[i].tmo);
      @(negedge sysclk) ign_coil = 1'b1;
      wait_cyc(10);
      ign_coil = 1'b0;
      wait_cyc(290);
      chk($sformatf("vec%0d_pending", i), exp_q.size(), 0, 0);
    end

    // Latency: injector opens on the third clock after the coil edge
    puff_len_us = 16'd20;
    push_norm(20);
    @(negedge sysclk) ign_coil = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    @(negedge sysclk);
    chk("open_after_2_clk", int'(injector_open), 0, 0);
    @(posedge sysclk);
    @(negedge sysclk);
    chk("open_after_3_clk", int'(injector_open), 1, 1);
    wait_cyc(60);
    ign_coil = 1'b0;
    wait_cyc(20);

    // Retrigger mid-puff and change length mid-puff: no extension, one event
    puff_len_us = 16'd50;
    push_norm(50);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(30);
    ign_coil = 1'b0;
    puff_len_us = 16'd5;
    wait_cyc(20);
    ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(200);
    chk("retrigger_pending", exp_q.size(), 0, 0);

    // Periodic edges reload the watchdog before it can fire
    ign_timeout_len_jf = 16'd4;
    puff_len_us = 16'd20;
    for (int i = 0; i < 7; i++) begin
      push_norm(20);
      @(negedge sysclk) ign_coil = 1'b1;
      wait_cyc(49);
      ign_coil = 1'b0;
      wait_cyc(i < 4 ? 50 : 60);
    end
    wait_cyc(300);
    chk("periodic_pending", exp_q.size(), 0, 0);
    // Watchdog has now stalled: next edge gives nothing, the following one a puff
    ign_timeout_len_jf = 16'd0;
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(100);
    push_norm(20);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(100);
    chk("stall_recovery_pending", exp_q.size(), 0, 0);

    // Enable drops mid-puff
    puff_len_us = 16'd50;
    push_abort(50);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(40);
    puff_enable = 1'b0;
    @(posedge sysclk);
    #1;
    chk("enable_drop_closes", int'(injector_open), 0, 0);
    wait_cyc(50);
    ign_coil = 1'b0;
    wait_cyc(20);
    ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(150);
    puff_enable = 1'b1;
    push_norm(50);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(150);
    chk("enable_pending", exp_q.size(), 0, 0);

    // Ignition edge and watchdog expiry in the same cycle: edge wins
    gen50 = 1'b0;
    pulse50k = 1'b0;
    ign_timeout_len_jf = 16'd1;
    puff_len_us = 16'd100;
    push_norm(100);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(20);
    ign_coil = 1'b0;
    wait_cyc(10);
    ign_coil = 1'b1;
    @(negedge sysclk) pulse50k = 1'b1;
    @(negedge sysclk) pulse50k = 1'b0;
    wait_cyc(250);
    chk("coincident_pending", exp_q.size(), 0, 0);
    ign_timeout_len_jf = 16'd0;
    puff_len_us = 16'd10;
    ign_coil = 1'b0;
    wait_cyc(5);
    push_norm(10);
    ign_coil = 1'b1;
    wait_cyc(40);
    gen50 = 1'b1;
    ign_coil = 1'b0;
    wait_cyc(20);

    // Reset mid-puff with the coil held high through release
    puff_len_us = 16'd50;
    push_abort(50);
    @(negedge sysclk) ign_coil = 1'b1;
    wait_cyc(30);
    #2 sysreset = 1'b0;
    #1;
    chk("reset_async_open", int'(injector_open), 0, 0);
    chk("reset_async_event", int'(puff_event), 0, 0);
    wait_cyc(5);
    sysreset = 1'b1;
    wait_cyc(100);
    chk("reset_release_pending", exp_q.size(), 0, 0);
    ign_coil = 1'b0;
    wait_cyc(10);
    puff_len_us = 16'd10;
    push_norm(10);
    ign_coil = 1'b1;
    wait_cyc(40);
    ign_coil = 1'b0;
    wait_cyc(20);

    chk("final_pending", exp_q.size(), 0, 0);
    chk("event_count", seen_events, exp_events, exp_events);
    chk("stray_events", stray_events, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
